conv_window_sequencer: RTL and testbench

Read-address sequencer for the 5-port data buffer in the convolution datapath. On a start pulse it walks every valid K×K window position over an IMG_W×IMG_H feature map stored row-major in the buffer. For each window it issues one beat per kernel row. Each beat drives K consecutive buffer addresses, one per read port, so the kernel MAC stage receives one full kernel row per accepted beat. Backpressure from the MAC stage is honoured through a valid/ready handshake.

---
 rtl/conv_window_sequencer_if.sv | 22 ++
 rtl/conv_window_sequencer.sv | 150 +++++++++++++++
 tb/tb_conv_window_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_sequencer_if.sv
// Beat bus between the window sequencer and the kernel MAC stage:
// one buffer read address per port plus window framing, with valid/ready.
interface conv_window_sequencer_if #(
    parameter int K          = 5,
    parameter int ADDR_WIDTH = 32
);
    logic [K*ADDR_WIDTH-1:0] rd_addr_NP;
    logic                    addr_valid;
    logic                    ready;
    logic                    win_first;
    logic                    win_last;

    modport master (
        output rd_addr_NP, addr_valid, win_first, win_last,
        input  ready
    );

    modport slave (
        input  rd_addr_NP, addr_valid, win_first, win_last,
        output ready
    );
endinterface

// File: rtl/conv_window_sequencer.sv
// Read-address sequencer for the K-port data buffer. Sweeps every valid
// KxK window of a row-major IMG_W x IMG_H map, one beat per kernel row,
// each beat carrying K consecutive addresses (one per read port).
module conv_window_sequencer #(
    parameter int                    IMG_W      = 32,
    parameter int                    IMG_H      = 32,
    parameter int                    K          = 5,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    conv_window_sequencer_if.master bus,
    output logic                    busy,
    output logic                    done
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int KW = $clog2(K + 1);
    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);

    localparam logic [KW-1:0]         KR_MAX = KW'(K - 1);
    localparam logic [XW-1:0]         OX_MAX = XW'(IMG_W - K);
    localparam logic [YW-1:0]         OY_MAX = YW'(IMG_H - K);
    localparam logic [ADDR_WIDTH-1:0] W_STEP = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] K_STEP = ADDR_WIDTH'(K);
    localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

    logic [1:0]                         state;
    logic [KW-1:0]                      kr, nxt_kr;
    logic [XW-1:0]                      ox;
    logic [YW-1:0]                      oy;
    // win_ptr: address of the window's top-left element; row_ptr: port-0
    // address of the current kernel row. Both advance by adds only.
    logic [ADDR_WIDTH-1:0]              win_ptr, row_ptr, nxt_win, nxt_row;
    logic [K-1:0][ADDR_WIDTH-1:0]       addr_q;
    logic                               valid_q, first_q, last_q;
    logic                               accept, last_kr, last_ox, last_oy;
    logic                               final_beat, load;

    assign bus.rd_addr_NP = addr_q;
    assign bus.addr_valid = valid_q;
    assign bus.win_first  = first_q;
    assign bus.win_last   = last_q;

    // addr_valid is high exactly while in RUN, so acceptance needs only ready
    assign accept     = (state == S_RUN) && bus.ready;
    assign last_kr    = (kr == KR_MAX);
    assign last_ox    = (ox == OX_MAX);
    assign last_oy    = (oy == OY_MAX);
    assign final_beat = last_kr && last_ox && last_oy;
    assign nxt_kr     = last_kr ? '0 : kr + KW'(1);

    // Next window/row pointers: down one map row within a window, one
    // column right between windows, and +K (= +IMG_W-(IMG_W-K)) on row wrap
    always_comb begin
        nxt_win = win_ptr;
        nxt_row = row_ptr;
        load    = 1'b0;
        if (state == S_IDLE && start) begin
            nxt_win = BASE_ADDR;
            nxt_row = BASE_ADDR;
            load    = 1'b1;
        end else if (accept && !final_beat) begin
            load = 1'b1;
            if (!last_kr) begin
                nxt_row = row_ptr + W_STEP;
            end else if (!last_ox) begin
                nxt_win = win_ptr + ONE;
                nxt_row = win_ptr + ONE;
            end else begin
                nxt_win = win_ptr + K_STEP;
                nxt_row = win_ptr + K_STEP;
            end
        end
    end

    // Registered pointers and per-port addresses; held during stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_ptr <= '0;
            row_ptr <= '0;
            addr_q  <= '0;
        end else if (load) begin
            win_ptr <= nxt_win;
            row_ptr <= nxt_row;
            for (int c = 0; c < K; c++) addr_q[c] <= nxt_row + ADDR_WIDTH'(c);
        end
    end

    // FSM, window counters and registered status/framing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            kr      <= '0;
            ox      <= '0;
            oy      <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= S_RUN;
                        kr      <= '0;
                        ox      <= '0;
                        oy      <= '0;
                        valid_q <= 1'b1;
                        busy    <= 1'b1;
                        first_q <= 1'b1;
                        last_q  <= (K == 1);
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (final_beat) begin
                            state   <= S_DONE;
                            valid_q <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            kr      <= nxt_kr;
                            first_q <= (nxt_kr == '0);
                            last_q  <= (nxt_kr == KR_MAX);
                            if (last_kr) begin
                                ox <= last_ox ? '0 : ox + XW'(1);
                                if (last_ox) oy <= oy + YW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops
// and compares every accepted beat and every done pulse.
module tb_conv_window_sequencer;
    localparam int K  = 5;
    localparam int AW = 32;

    typedef struct {
        logic [K-1:0][AW-1:0] addr;
        logic                 first;
        logic                 last;
        logic                 fin;
    } beat_t;

    logic clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, rdy = 1'b1, use_b = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    always #5 clk = ~clk;

    conv_window_sequencer_if #(.K(K), .ADDR_WIDTH(AW)) ifa ();
    conv_window_sequencer_if #(.K(K), .ADDR_WIDTH(AW)) ifb ();
    assign ifa.ready = rdy;
    assign ifb.ready = rdy;

    conv_window_sequencer #(.IMG_W(8), .IMG_H(8), .K(K), .ADDR_WIDTH(AW), .BASE_ADDR(32'h100))
        dut_a (.clk(clk), .rst_n(rst_n), .start(start_a), .bus(ifa), .busy(busy_a), .done(done_a));
    conv_window_sequencer #(.IMG_W(5), .IMG_H(5), .K(K), .ADDR_WIDTH(AW), .BASE_ADDR(32'hFFFF_FFFE))
        dut_b (.clk(clk), .rst_n(rst_n), .start(start_b), .bus(ifb), .busy(busy_b), .done(done_b));

    logic [K-1:0][AW-1:0] m_addr;
    logic m_valid, m_first, m_last, m_busy, m_done;
    assign m_addr  = use_b ? ifb.rd_addr_NP : ifa.rd_addr_NP;
    assign m_valid = use_b ? ifb.addr_valid : ifa.addr_valid;
    assign m_first = use_b ? ifb.win_first  : ifa.win_first;
    assign m_last  = use_b ? ifb.win_last   : ifa.win_last;
    assign m_busy  = use_b ? busy_b : busy_a;
    assign m_done  = use_b ? done_b : done_a;

    int tests = 0, fails = 0;
    int beats_seen = 0, done_cnt = 0, pres = 0, hold2 = 0;
    bit done_due = 0, prev_stall = 0;
    logic [K-1:0][AW-1:0] prev_addr;
    logic prev_first, prev_last;
    logic [K-1:0][AW-1:0] seen [128];
    beat_t q[$];

    task automatic chk(input string name, input logic [167:0] got, input logic [167:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected beats from the direct address formula
    task automatic push_exp(input int w, input int h, input logic [AW-1:0] base);
        beat_t e;
        for (int oy = 0; oy <= h - K; oy++)
            for (int ox = 0; ox <= w - K; ox++)
                for (int kr = 0; kr < K; kr++) begin
                    for (int c = 0; c < K; c++) e.addr[c] = base + AW'((oy + kr) * w + ox + c);
                    e.first = (kr == 0);
                    e.last  = (kr == K - 1);
                    e.fin   = (oy == h - K) && (ox == w - K) && (kr == K - 1);
                    q.push_back(e);
                end
    endtask

    // Monitor: done framing first, then stall stability, then accepted beats
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done_due) begin
                    chk("done_pulse", {m_done, m_busy, m_valid, m_first, m_last}, 5'b10000);
                    done_due = 0;
                    done_cnt++;
                end else if (m_done) begin
                    chk("spurious_done", m_done, 1'b0);
                end
                if (m_valid) begin
                    pres++;
                    if (prev_stall)
                        chk("stall_hold", {m_addr, m_first, m_last}, {prev_addr, prev_first, prev_last});
                    if (rdy) begin
                        if (q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL extra_beat got=%0h exp=none", m_addr);
                        end else begin
                            e = q.pop_front();
                            chk("beat", {m_addr, m_first, m_last}, {e.addr, e.first, e.last});
                            if (e.fin) done_due = 1;
                        end
                        if (beats_seen < 128) seen[beats_seen] = m_addr;
                        if (beats_seen == 2) hold2 = pres;
                        pres = 0;
                        beats_seen++;
                    end
                end
                prev_stall = m_valid && !rdy;
                prev_addr  = m_addr;
                prev_first = m_first;
                prev_last  = m_last;
            end
        end
    end

    task automatic pulse_start(input bit b);
        @(posedge clk); #1;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        @(negedge clk);
        chk("start_latency", {m_valid, m_busy, m_first}, 3'b111);
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin @(posedge clk); n++; end
        if (done_cnt == d0) begin
            tests++; fails++;
            $display("FAIL done_timeout got=%0d exp=%0d", done_cnt, d0 + 1);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beats_seen < n && t < 2000) begin @(negedge clk); t++; end
        if (beats_seen < n) begin
            tests++; fails++;
            $display("FAIL beat_timeout got=%0d exp=%0d", beats_seen, n);
        end
    endtask

    initial begin
        int d0;
        #12;
        chk("reset_a", {ifa.rd_addr_NP, ifa.addr_valid, ifa.win_first, ifa.win_last, busy_a, done_a}, '0);
        chk("reset_b", {ifb.rd_addr_NP, ifb.addr_valid, ifb.win_first, ifb.win_last, busy_b, done_b}, '0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Basic windows and full sweep
        push_exp(8, 8, 32'h100); beats_seen = 0; d0 = done_cnt;
        pulse_start(0); wait_done(d0);
        chk("sweep_beats", beats_seen, 80);
        chk("queue_empty", q.size(), 0);
        chk("beat0", seen[0], {32'h104, 32'h103, 32'h102, 32'h101, 32'h100});
        chk("beat1_p0", seen[1][0], 32'h108);
        chk("beat4_p0", seen[4][0], 32'h120);
        chk("beat5_p0", seen[5][0], 32'h101);
        chk("beat79", seen[79], {32'h13F, 32'h13E, 32'h13D, 32'h13C, 32'h13B});
        chk("done_once", done_cnt, d0 + 1);

        // Backpressure during beat 2
        push_exp(8, 8, 32'h100); beats_seen = 0; d0 = done_cnt;
        fork
            begin pulse_start(0); wait_done(d0); end
            begin
                wait_beats(2);
                @(posedge clk); #1 rdy = 1'b0;
                repeat (3) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        chk("stall_beats", beats_seen, 80);
        chk("stall_hold_len", hold2, 4);
        chk("stall_beat2_p0", seen[2][0], 32'h110);

        // start re-pulsed mid-sweep
        push_exp(8, 8, 32'h100); beats_seen = 0; d0 = done_cnt;
        fork
            begin pulse_start(0); wait_done(d0); end
            begin
                wait_beats(10);
                @(posedge clk); #1 start_a = 1'b1;
                @(posedge clk); #1 start_a = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        chk("midstart_beats", beats_seen, 80);
        chk("midstart_done", done_cnt, d0 + 1);

        // Async reset at beat 37
        push_exp(8, 8, 32'h100); beats_seen = 0; d0 = done_cnt;
        pulse_start(0);
        wait_beats(37);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("async_reset", {ifa.rd_addr_NP, ifa.addr_valid, ifa.win_first, ifa.win_last, busy_a, done_a}, '0);
        q.delete(); done_due = 0; prev_stall = 0; pres = 0;
        repeat (2) @(posedge clk); #3 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("no_done_after_reset", done_cnt, d0);
        push_exp(8, 8, 32'h100); beats_seen = 0; d0 = done_cnt;
        pulse_start(0); wait_done(d0);
        chk("post_reset_beat0", seen[0], {32'h104, 32'h103, 32'h102, 32'h101, 32'h100});
        chk("post_reset_beats", beats_seen, 80);

        // Address wrap at top of address space
        use_b = 1'b1;
        push_exp(5, 5, 32'hFFFF_FFFE); beats_seen = 0; d0 = done_cnt;
        pulse_start(1); wait_done(d0);
        chk("wrap_beat0", seen[0], {32'h2, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        chk("wrap_beats", beats_seen, 5);
        chk("wrap_done", done_cnt, d0 + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
